spi_cmd_slave: RTL
==================

// Module: spi_cmd_slave
// PURPOSE
//  Clock-domain SPI slave: oversamples sclk/mosi/cs_n on clk and decodes NPU command frames.
//  Frame fields: cmd, tile_i, tile_j, op, data. All field widths and the SPI mode are parameters.
//  Returns a readback word on miso during the frame. Feeds the NPU command decoder.
//  Field outputs change only on clk edges, never on sclk edges.
// PARAMETERS
//  CMD_W   8  command field width
//  TILE_W  3  tile_i / tile_j field width (2**TILE_W tiles per axis)
//  OP_W    2  op-code field width
//  DATA_W  8  data field width; also the readback (resp) width
//  CPOL    0  sclk idle level
//  CPHA    0  0: sample on leading edge, shift on trailing; 1: the reverse
//  FRAME_W (localparam) = CMD_W + 2*TILE_W + OP_W + DATA_W, default 24
// PORTS
//  clk         in   1        system clock; sclk must be <= clk/8
//  rst_n       in   1        async active-low reset
//  sclk        in   1        SPI clock (async)
//  mosi        in   1        SPI data in (async)
//  cs_n        in   1        SPI chip select, active low (async)
//  miso        out  1        SPI data out
//  miso_oe     out  1        miso drive enable; equals ~cs_n after sync
//  resp_req    out  1        1-clk pulse when the cmd field is complete
//  resp_cmd    out  CMD_W    cmd field; valid from resp_req onward
//  resp_data   in   DATA_W   readback word; sampled 2 clk after resp_req
//  frm_valid   out  1        1-clk pulse: fields below hold a good frame
//  frm_cmd     out  CMD_W    decoded cmd field
//  frm_tile_i  out  TILE_W   decoded tile_i field
//  frm_tile_j  out  TILE_W   decoded tile_j field
//  frm_op      out  OP_W     decoded op field
//  frm_data    out  DATA_W   decoded data field
//  frm_err     out  1        1-clk pulse on abort, overrun or (opt.) parity error
// BEHAVIOUR
//  - Sync: sclk, mosi and cs_n each pass a 2-FF synchroniser.
//    sclk edges are detected from the synchronised value; one detected edge = one SPI edge.
//  - Frame: MSB first, order {cmd, tile_i, tile_j, op, data}, non-overlapping fields.
//  - FSM IDLE -> SHIFT on cs_n falling (sync). Bit counter is cleared on entry.
//    - SHIFT: on each sample edge, shift mosi into the shift register and increment the counter.
//    - SHIFT -> DONE at count == FRAME_W. frm_* load and frm_valid pulses in that cycle.
//      Latency is 1 clk after the last synchronised sample edge.
//    - DONE: further sample edges set an overrun flag. frm_err pulses once, on the first extra edge.
//    - Any state -> IDLE on cs_n rising (sync).
//  - Abort: cs_n rises in SHIFT with count < FRAME_W.
//    frm_err pulses; frm_valid does not pulse; frm_* keep their previous values.
//  - Readback: resp_req pulses at count == CMD_W, with resp_cmd valid.
//    - resp_data is loaded into the tx register exactly 2 clk later.
//    - miso then shifts the tx register MSB first on shift edges for the next DATA_W bits.
//    - Outside that window miso = 0.
//    - If CMD_W bits arrive before the load, miso = 0 for the missed bits.
//  - CPHA=1: the first leading edge is a shift edge, so no sample occurs on it.
//  - Reset: every output is 0. FSM = IDLE; counter, shift reg and tx reg = 0.
//    cs_n held high during reset is treated as idle.
//  - Reset mid-frame: the frame is discarded with no pulses. The next cs_n fall starts clean.
//  - Simultaneous cs_n rise and final sample edge in the same clk: the sample counts first.
//    If count then reaches FRAME_W, frm_valid pulses and there is no abort.
// CONFIGURATION
//  SPI_CMD_PARITY_EN defined:
//    - FRAME_W grows by 1. One odd-parity bit over all field bits follows data.
//    - On mismatch: frm_err pulses, frm_valid is suppressed, frm_* are not updated.
//  Not defined: no parity bit; behaviour is exactly as above.
// STRUCTURE
//  - Package npu_spi_pkg holds the spi_frame_t packed struct {cmd, tile_i, tile_j, op, data}.
//    Default widths come from package localparams.
//  - Package npu_spi_pkg also holds the FSM state enum (IDLE, SHIFT, DONE).
//  - Sub-module spi_edge_sync: 2-FF synchroniser plus rise/fall detect, instanced per input.
// TESTING
//  - Mode 0, frame 0x5AAB3C: frm_valid x1 with cmd=0x5A, tile_i=5, tile_j=2, op=3, data=0x3C. frm_err=0.
//  - Readback, mode 0: resp_data=0xC3 held from resp_req. miso bits 8..15 = 1100_0011; miso=0 elsewhere.
//  - Abort: cs_n rises after 12 bits. frm_err pulses once, no frm_valid, frm_* unchanged.
//  - Overrun: 26 bits clocked. frm_valid pulses at bit 24, frm_err pulses at bit 25.
//  - Modes 1/2/3: rerun 0x5AAB3C per mode. Identical fields each time.
//  - Reset mid-frame, then a full frame 0x000001: only that frame reported, data=0x01.
//  - SPI_CMD_PARITY_EN: bad parity -> frm_err, no frm_valid. Good parity -> frm_valid.

Source files
------------

// File: rtl/npu_spi_pkg.sv
// npu_spi_pkg: shared frame layout, default field widths and slave FSM states
package npu_spi_pkg;
    localparam int DEF_CMD_W  = 8;
    localparam int DEF_TILE_W = 3;
    localparam int DEF_OP_W   = 2;
    localparam int DEF_DATA_W = 8;
    typedef struct packed {
        logic [DEF_CMD_W-1:0]  cmd;
        logic [DEF_TILE_W-1:0] tile_i;
        logic [DEF_TILE_W-1:0] tile_j;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_DATA_W-1:0] data;
    } spi_frame_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-FF synchroniser with rise/fall pulses taken from the synchronised level
module spi_edge_sync #(
    parameter bit INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic meta, prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {meta, q, prev} <= {3{INIT}};
        else {meta, q, prev} <= {d, meta, q};
    end
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: oversampled SPI slave decoding NPU command frames with miso readback
// Optional odd-parity bit after data when SPI_CMD_PARITY_EN is defined.
module spi_cmd_slave
    import npu_spi_pkg::*;
#(
    parameter int CMD_W  = DEF_CMD_W,
    parameter int TILE_W = DEF_TILE_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    output logic              resp_req,
    output logic [CMD_W-1:0]  resp_cmd,
    input  logic [DATA_W-1:0] resp_data,
    output logic              frm_valid,
    output logic [CMD_W-1:0]  frm_cmd,
    output logic [TILE_W-1:0] frm_tile_i,
    output logic [TILE_W-1:0] frm_tile_j,
    output logic [OP_W-1:0]   frm_op,
    output logic [DATA_W-1:0] frm_data,
    output logic              frm_err
);
`ifdef SPI_CMD_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FLD_W   = CMD_W + 2*TILE_W + OP_W + DATA_W;
    localparam int FRAME_W = FLD_W + PAR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic sclk_q_unused, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;
    logic cs_q, cs_rise, cs_fall;
    logic sample, shift_e, par_ok, last, in_win;
    logic ld_pend, loaded, ovr;
    logic [CNT_W-1:0]   count, cnt_n;
    logic [FRAME_W-1:0] sh, sh_n;
    logic [FLD_W-1:0]   fld;
    logic [DATA_W-1:0]  tx, tx_sh;
    spi_state_t         state;

    spi_edge_sync #(.INIT(CPOL)) u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_sync #(.INIT(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
    spi_edge_sync #(.INIT(1'b1)) u_cs (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));

    always_comb begin
        sample  = CPHA ? (CPOL ? sclk_rise : sclk_fall) : (CPOL ? sclk_fall : sclk_rise);
        shift_e = CPHA ? (CPOL ? sclk_fall : sclk_rise) : (CPOL ? sclk_rise : sclk_fall);
        cnt_n   = count + CNT_W'(1);
        sh_n    = {sh[FRAME_W-2:0], mosi_q};
        fld     = sh_n[FRAME_W-1 -: FLD_W];
        par_ok  = (PAR_W == 0) || (^sh_n);
        last    = sample && cnt_n == CNT_W'(FRAME_W);
        // at a shift edge the bit being presented always has index == count
        in_win  = count >= CNT_W'(CMD_W) && count < CNT_W'(CMD_W + DATA_W);
        tx_sh   = tx << (count - CNT_W'(CMD_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            sh         <= '0;
            tx         <= '0;
            ld_pend    <= 1'b0;
            loaded     <= 1'b0;
            ovr        <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            resp_req   <= 1'b0;
            resp_cmd   <= '0;
            frm_valid  <= 1'b0;
            frm_cmd    <= '0;
            frm_tile_i <= '0;
            frm_tile_j <= '0;
            frm_op     <= '0;
            frm_data   <= '0;
            frm_err    <= 1'b0;
        end else begin
            frm_valid <= 1'b0;
            frm_err   <= 1'b0;
            resp_req  <= 1'b0;
            miso_oe   <= ~cs_q;
            ld_pend   <= resp_req;
            if (ld_pend) begin
                tx     <= resp_data;
                loaded <= 1'b1;
            end
            if (shift_e) miso <= in_win && loaded && tx_sh[DATA_W-1];
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        state  <= SHIFT;
                        count  <= '0;
                        sh     <= '0;
                        loaded <= 1'b0;
                        ovr    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sample) begin
                        sh    <= sh_n;
                        count <= cnt_n;
                    end
                    if (sample && cnt_n == CNT_W'(CMD_W)) begin
                        resp_req <= 1'b1;
                        resp_cmd <= sh_n[CMD_W-1:0];
                    end
                    if (last) begin
                        state     <= DONE;
                        frm_valid <= par_ok;
                        frm_err   <= !par_ok;
                        if (par_ok) begin
                            frm_cmd    <= fld[FLD_W-1 -: CMD_W];
                            frm_tile_i <= fld[DATA_W+OP_W+TILE_W +: TILE_W];
                            frm_tile_j <= fld[DATA_W+OP_W +: TILE_W];
                            frm_op     <= fld[DATA_W +: OP_W];
                            frm_data   <= fld[DATA_W-1:0];
                        end
                    end
                    // a final sample landing with cs_n rise still completes the frame
                    if (cs_rise) begin
                        state <= IDLE;
                        if (!last) frm_err <= 1'b1;
                    end
                end
                DONE: begin
                    if (sample && !ovr) begin
                        ovr     <= 1'b1;
                        frm_err <= 1'b1;
                    end
                    if (cs_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
